// File: rtl/reg_file_sb_if.sv
// Issue / writeback / read bundle for reg_file_sb.
// master = core side driving requests, slave = register file.
interface reg_file_sb_if #(
  parameter int DATA_W   = 32,
  parameter int REG_NUM  = 32,
  parameter int RD_PORTS = 2
);
  localparam int ADDR_W = $clog2(REG_NUM);

  logic [RD_PORTS-1:0]        iRdEn;
  logic [RD_PORTS*ADDR_W-1:0] iRdAddr;
  logic [RD_PORTS*DATA_W-1:0] oRdData;
  logic [RD_PORTS-1:0]        oRdBusy;
  logic                       iResEn;
  logic [ADDR_W-1:0]          iResAddr;
  logic                       oResRdy;
  logic                       iWrEn;
  logic [ADDR_W-1:0]          iWrAddr;
  logic [DATA_W-1:0]          iWrData;
  logic [REG_NUM-1:0]         oBusyVec;
  logic [ADDR_W:0]            oPendCnt;

  modport master (
    output iRdEn, iRdAddr,
    output iResEn, iResAddr,
    output iWrEn, iWrAddr, iWrData,
    input  oRdData, oRdBusy, oResRdy,
    input  oBusyVec, oPendCnt
  );

  modport slave (
    input  iRdEn, iRdAddr,
    input  iResEn, iResAddr,
    input  iWrEn, iWrAddr, iWrData,
    output oRdData, oRdBusy, oResRdy,
    output oBusyVec, oPendCnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write-pending scoreboard, x0 = 0.
// Optional REGFILE_BYPASS_EN forwards same-cycle writeback to read ports.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int REG_NUM  = 32,
  parameter int RD_PORTS = 2
) (
  input logic          iClk,
  input logic          iRst,
  reg_file_sb_if.slave bus
);
  localparam int ADDR_W = $clog2(REG_NUM);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0]  rf_q [REG_NUM];
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic wr_hit;
  logic res_rdy;
  logic res_go;
  logic same;
  logic inc, dec;

  assign wr_hit = bus.iWrEn && (bus.iWrAddr != '0);
  assign same   = bus.iWrEn && (bus.iWrAddr == bus.iResAddr);

  assign res_rdy = (bus.iResAddr == '0)
                 | ~busy_q[bus.iResAddr]
                 | same;

  assign res_go = bus.iResEn && res_rdy
               && (bus.iResAddr != '0);

  // A reservation colliding with its own release nets zero.
  assign inc = res_go && !busy_q[bus.iResAddr];
  assign dec = wr_hit && busy_q[bus.iWrAddr]
            && !(res_go && same);

  always_comb begin
    busy_d = busy_q;
    if (wr_hit) busy_d[bus.iWrAddr] = 1'b0;
    if (res_go) busy_d[bus.iResAddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      for (int i = 0; i < REG_NUM; i++)
        rf_q[i] <= '0;
    end else if (wr_hit) begin
      rf_q[bus.iWrAddr] <= bus.iWrData;
    end
  end

  logic [ADDR_W-1:0]          ra [RD_PORTS];
  logic [RD_PORTS-1:0]        hit;
  logic [RD_PORTS-1:0]        fwd;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_busy;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    hit     = '0;
    fwd     = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      ra[p]  = bus.iRdAddr[p*ADDR_W +: ADDR_W];
      hit[p] = bus.iRdEn[p] && (ra[p] != '0);
`ifdef REGFILE_BYPASS_EN
      fwd[p] = hit[p] && wr_hit
            && (bus.iWrAddr == ra[p]);
`else
      fwd[p] = 1'b0;
`endif
      if (fwd[p]) begin
        rd_data[p*DATA_W +: DATA_W] = bus.iWrData;
      end else if (hit[p]) begin
        rd_data[p*DATA_W +: DATA_W] = rf_q[ra[p]];
        rd_busy[p] = busy_q[ra[p]];
      end
    end
  end

  assign bus.oRdData  = rd_data;
  assign bus.oRdBusy  = rd_busy;
  assign bus.oResRdy  = res_rdy;
  assign bus.oBusyVec = busy_q;
  assign bus.oPendCnt = cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vectors, array/popcount reference
// model checked every negedge, plus literal expectations.
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int RN = 32;
  localparam int RP = 4;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;

  reg_file_sb_if #(.DATA_W(DW), .REG_NUM(RN), .RD_PORTS(RP)) bus ();

  reg_file_sb #(.DATA_W(DW), .REG_NUM(RN), .RD_PORTS(RP)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural contents and pending set.
  logic [DW-1:0] mrf [RN] = '{default: '0};
  logic [RN-1:0] mbusy = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RN; i++) mrf[i] = '0;
      mbusy = '0;
    end else begin
      bit ok;
      int wa, ra;
      wa = int'(bus.iWrAddr);
      ra = int'(bus.iResAddr);
      ok = (ra == 0) || !mbusy[ra] || (bus.iWrEn && wa == ra);
      if (bus.iWrEn && wa != 0) begin
        mrf[wa] = bus.iWrData;
        mbusy[wa] = 1'b0;
      end
      if (bus.iResEn && ok && ra != 0) mbusy[ra] = 1'b1;
    end
  end

  always @(negedge clk) begin
    int a, ra, wa;
    logic [DW-1:0] ed;
    logic eb;
    bit ok;
    wa = int'(bus.iWrAddr);
    for (int p = 0; p < RP; p++) begin
      a = int'(bus.iRdAddr[p*AW +: AW]);
      ed = '0;
      eb = 1'b0;
      if (bus.iRdEn[p] && a != 0) begin
        if (BYP && rst && bus.iWrEn && wa == a) begin
          ed = bus.iWrData;
        end else begin
          ed = mrf[a];
          eb = mbusy[a];
        end
      end
      chk($sformatf("rd_data%0d", p), 64'(bus.oRdData[p*DW +: DW]), 64'(ed));
      chk($sformatf("rd_busy%0d", p), 64'(bus.oRdBusy[p]), 64'(eb));
    end
    ra = int'(bus.iResAddr);
    ok = (ra == 0) || !mbusy[ra] || (bus.iWrEn && wa == ra);
    chk("res_rdy", 64'(bus.oResRdy), 64'(ok));
    chk("busy_vec", 64'(bus.oBusyVec), 64'(mbusy));
    chk("pend_cnt", 64'(bus.oPendCnt), 64'($countones(mbusy)));
  end

  task automatic idle();
    bus.iRdEn    = '0;
    bus.iRdAddr  = '0;
    bus.iResEn   = 1'b0;
    bus.iResAddr = '0;
    bus.iWrEn    = 1'b0;
    bus.iWrAddr  = '0;
    bus.iWrData  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int p, input int a);
    logic [AW-1:0] av;
    av = AW'(a);
    bus.iRdEn[p] = 1'b1;
    bus.iRdAddr[p*AW +: AW] = av;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    bus.iWrEn   = 1'b1;
    bus.iWrAddr = AW'(a);
    bus.iWrData = d;
  endtask

  task automatic res(input int a);
    bus.iResEn   = 1'b1;
    bus.iResAddr = AW'(a);
  endtask

  function automatic logic [DW-1:0] dat(input int p);
    return bus.oRdData[p*DW +: DW];
  endfunction

  initial begin
    idle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.iRdEn    = RP'($urandom);
      bus.iRdAddr  = (RP*AW)'($urandom);
      bus.iResEn   = 1'($urandom);
      bus.iResAddr = AW'($urandom);
      bus.iWrAddr  = AW'($urandom);
      bus.iWrData  = $urandom;
      @(negedge clk);
      chk("rst_pend", 64'(bus.oPendCnt), 64'd0);
      chk("rst_busyvec", 64'(bus.oBusyVec), 64'd0);
      chk("rst_rdy", 64'(bus.oResRdy), 64'd1);
      chk("rst_data", 64'(bus.oRdData[63:0]), 64'd0);
      tick();
    end
    rst = 1'b1;
    idle();

    // x0 stays zero
    res(0);
    wr(0, 32'hDEADBEEF);
    rd(0, 0);
    tick();
    idle();
    rd(0, 0);
    @(negedge clk);
    chk("x0_data", 64'(dat(0)), 64'd0);
    chk("x0_busy", 64'(bus.oRdBusy[0]), 64'd0);
    chk("x0_pend", 64'(bus.oPendCnt), 64'd0);
    tick();

    // reserve then write r5
    idle();
    res(5);
    @(negedge clk);
    chk("r5_rdy", 64'(bus.oResRdy), 64'd1);
    tick();
    idle();
    rd(0, 5);
    res(5);
    @(negedge clk);
    chk("r5_busy", 64'(bus.oRdBusy[0]), 64'd1);
    chk("r5_pend", 64'(bus.oPendCnt), 64'd1);
    chk("r5_rdy2", 64'(bus.oResRdy), 64'd0);
    tick();
    idle();
    rd(0, 5);
    wr(5, 32'h12345678);
    tick();
    idle();
    rd(0, 5);
    @(negedge clk);
    chk("r5_data", 64'(dat(0)), 64'h12345678);
    chk("r5_free", 64'(bus.oRdBusy[0]), 64'd0);
    chk("r5_pend0", 64'(bus.oPendCnt), 64'd0);
    tick();

    // same-address write + reserve on r7
    idle();
    res(7);
    tick();
    idle();
    wr(7, 32'hA5A5A5A5);
    res(7);
    @(negedge clk);
    chk("r7_rdy", 64'(bus.oResRdy), 64'd1);
    tick();
    idle();
    rd(0, 7);
    @(negedge clk);
    chk("r7_data", 64'(dat(0)), 64'hA5A5A5A5);
    chk("r7_busy", 64'(bus.oRdBusy[0]), 64'd1);
    chk("r7_pend", 64'(bus.oPendCnt), 64'd1);
    tick();

    // four ports, r2 busy
    idle();
    wr(1, 32'h11111111);
    tick();
    idle();
    wr(2, 32'h22222222);
    tick();
    idle();
    res(2);
    tick();
    idle();
    rd(0, 1);
    rd(1, 2);
    rd(2, 1);
    rd(3, 0);
    @(negedge clk);
    chk("mp_d0", 64'(dat(0)), 64'h11111111);
    chk("mp_d1", 64'(dat(1)), 64'h22222222);
    chk("mp_d2", 64'(dat(2)), 64'h11111111);
    chk("mp_d3", 64'(dat(3)), 64'd0);
    chk("mp_busy", 64'(bus.oRdBusy), 64'b0010);
    chk("mp_pend", 64'(bus.oPendCnt), 64'd2);
    tick();

    // same-cycle write/read of r9
    idle();
    wr(9, 32'h55);
    tick();
    idle();
    wr(9, 32'hFF);
    rd(0, 9);
    @(negedge clk);
    chk("byp_data", 64'(dat(0)), BYP ? 64'hFF : 64'h55);
    chk("byp_busy", 64'(bus.oRdBusy[0]), 64'd0);
    tick();
    idle();
    rd(0, 9);
    @(negedge clk);
    chk("byp_next", 64'(dat(0)), 64'hFF);
    tick();

    // mixed traffic on a narrow address range
    for (int c = 0; c < 60; c++) begin
      idle();
      bus.iRdEn = RP'($urandom);
      for (int p = 0; p < RP; p++) rd(p, int'($urandom_range(0, 11)));
      bus.iRdEn = RP'($urandom);
      if ($urandom_range(0, 1) == 1) res(int'($urandom_range(0, 11)));
      if ($urandom_range(0, 2) != 0) wr(int'($urandom_range(0, 11)), $urandom);
      tick();
    end

    // reset in the middle of traffic
    idle();
    wr(3, 32'hCAFEF00D);
    res(4);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_pend", 64'(bus.oPendCnt), 64'd0);
    chk("mid_vec", 64'(bus.oBusyVec), 64'd0);
    tick();
    rst = 1'b1;
    idle();
    rd(0, 3);
    rd(1, 1);
    @(negedge clk);
    chk("mid_r3", 64'(dat(0)), 64'd0);
    chk("mid_r1", 64'(dat(1)), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
